// File: rtl/data_sync.sv
// data_sync: multi-bit clock-domain crossing into the Clk domain.
// A level enable from a foreign domain passes through a NUM_STAGES-deep flop chain.
// Each rising edge of the synchronized enable produces a one-cycle EnablePulse and
// captures the quasi-static UnsyncBus into SyncBus. A valid/ready holding stage with
// a sticky overrun flag lets the consumer take the word at its own pace.
//
// Ports:
//   Clk         destination clock; all flops use its rising edge
//   Reset_n     synchronous active-low reset
//   UnsyncBus   foreign-domain data; it must be stable while a transfer is in flight
//   BusEnable   asynchronous level; a 0->1 transition announces new data
//   SyncBus     registered captured data
//   EnablePulse registered one-cycle strobe, high in the cycle SyncBus updates
//   SyncValid   a captured word is held and has not been consumed yet
//   SyncReady   consumer accepts the held word when SyncValid && SyncReady
//   Overrun     sticky; set when a capture overwrote an unconsumed word
//   ClrOverrun  clears Overrun; a set in the same cycle wins
module data_sync #(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned BUS_WIDTH  = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [BUS_WIDTH-1:0] UnsyncBus,
  input  logic                 BusEnable,
  output logic [BUS_WIDTH-1:0] SyncBus,
  output logic                 EnablePulse,
  output logic                 SyncValid,
  input  logic                 SyncReady,
  output logic                 Overrun,
  input  logic                 ClrOverrun
);

  logic [NUM_STAGES-1:0] chain_q, chain_d;
  logic                  sync_q, sync_d;
  logic [BUS_WIDTH-1:0]  sync_bus_q, sync_bus_d;
  logic                  pulse_q, pulse_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  cap;
  logic                  consume;

  // Rising edge of the synchronized enable; falling edges are ignored.
  assign cap     = chain_q[NUM_STAGES-1] && !sync_q;
  assign consume = valid_q && SyncReady;

  always_comb begin
    chain_d    = {chain_q[NUM_STAGES-2:0], BusEnable};
    sync_d     = chain_q[NUM_STAGES-1];
    sync_bus_d = sync_bus_q;
    pulse_d    = 1'b0;
    valid_d    = valid_q;
    overrun_d  = overrun_q && !ClrOverrun;

    if (cap) begin
      sync_bus_d = UnsyncBus;
      pulse_d    = 1'b1;
      valid_d    = 1'b1;
      // A capture that coincides with a consume replaces the old word cleanly.
      if (valid_q && !SyncReady) begin
        overrun_d = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      chain_q    <= '0;
      sync_q     <= 1'b0;
      sync_bus_q <= '0;
      pulse_q    <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      chain_q    <= chain_d;
      sync_q     <= sync_d;
      sync_bus_q <= sync_bus_d;
      pulse_q    <= pulse_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign SyncBus     = sync_bus_q;
  assign EnablePulse = pulse_q;
  assign SyncValid   = valid_q;
  assign Overrun     = overrun_q;

endmodule

// File: tb/tb_data_sync.sv
module tb_data_sync;

  logic       clk;
  logic       reset_n;
  logic [7:0] unsync_bus;
  logic       bus_enable;
  logic       sync_ready;
  logic       clr_overrun;

  logic [7:0] bus2, bus3;
  logic       pulse2, pulse3;
  logic       valid2, valid3;
  logic       ovr2, ovr3;

  int n_checks;
  int n_fail;

  data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8)) u_dut2 (
    .Clk         (clk),
    .Reset_n     (reset_n),
    .UnsyncBus   (unsync_bus),
    .BusEnable   (bus_enable),
    .SyncBus     (bus2),
    .EnablePulse (pulse2),
    .SyncValid   (valid2),
    .SyncReady   (sync_ready),
    .Overrun     (ovr2),
    .ClrOverrun  (clr_overrun)
  );

  data_sync #(.NUM_STAGES(3), .BUS_WIDTH(8)) u_dut3 (
    .Clk         (clk),
    .Reset_n     (reset_n),
    .UnsyncBus   (unsync_bus),
    .BusEnable   (bus_enable),
    .SyncBus     (bus3),
    .EnablePulse (pulse3),
    .SyncValid   (valid3),
    .SyncReady   (sync_ready),
    .Overrun     (ovr3),
    .ClrOverrun  (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs and samples are taken 1 ns after the rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full transfer with the consumer idle: enable high 5 edges, then low 5 edges.
  task automatic send(input logic [7:0] data);
    unsync_bus = data;
    bus_enable = 1'b1;
    tick(5);
    bus_enable = 1'b0;
    tick(5);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    unsync_bus  = 8'h00;
    bus_enable  = 1'b0;
    sync_ready  = 1'b0;
    clr_overrun = 1'b0;

    // Reset held while BusEnable toggles: no strobe ever appears.
    for (int i = 0; i < 4; i++) begin
      bus_enable = i[0];
      tick(1);
      check_eq("rst_pulse2", pulse2, 0);
      check_eq("rst_pulse3", pulse3, 0);
    end
    bus_enable = 1'b0;
    tick(1);
    check_eq("rst_bus", bus2, 8'h00);
    check_eq("rst_pulse", pulse2, 0);
    check_eq("rst_valid", valid2, 0);
    check_eq("rst_ovr", ovr2, 0);
    reset_n = 1'b1;
    tick(3);
    check_eq("idle_pulse", pulse2, 0);

    // First transfer: enable raised before edge 0, strobe after edge 2 (N=2), edge 3 (N=3).
    unsync_bus = 8'hA5;
    bus_enable = 1'b1;
    tick(1);
    check_eq("lat_e0", pulse2, 0);
    tick(1);
    check_eq("lat_e1", pulse2, 0);
    tick(1);
    check_eq("lat_e2_pulse", pulse2, 1);
    check_eq("lat_e2_bus", bus2, 8'hA5);
    check_eq("lat_e2_valid", valid2, 1);
    check_eq("lat_e2_pulse3", pulse3, 0);
    tick(1);
    check_eq("width_pulse", pulse2, 0);
    check_eq("lat3_pulse", pulse3, 1);
    check_eq("lat3_bus", bus3, 8'hA5);
    sync_ready = 1'b1;
    tick(1);
    check_eq("consume_valid", valid2, 0);
    sync_ready = 1'b0;
    tick(1);
    // Falling edge of the enable must not strobe.
    bus_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_eq("fall_pulse2", pulse2, 0);
      check_eq("fall_pulse3", pulse3, 0);
    end

    // Second transfer after a consume: no overrun.
    send(8'h3C);
    check_eq("x2_bus", bus2, 8'h3C);
    check_eq("x2_valid", valid2, 1);
    check_eq("x2_ovr", ovr2, 0);
    sync_ready = 1'b1;
    tick(1);
    check_eq("x2_consume", valid2, 0);
    sync_ready = 1'b0;

    // Two unconsumed transfers: overwrite and sticky overrun.
    send(8'h11);
    check_eq("ovr_first_bus", bus2, 8'h11);
    check_eq("ovr_first_flag", ovr2, 0);
    send(8'h22);
    check_eq("ovr_bus", bus2, 8'h22);
    check_eq("ovr_flag", ovr2, 1);
    tick(3);
    check_eq("ovr_sticky", ovr2, 1);
    clr_overrun = 1'b1;
    tick(1);
    check_eq("ovr_clear", ovr2, 0);
    clr_overrun = 1'b0;

    // Clear in the same cycle as a set: set wins.
    unsync_bus = 8'h33;
    bus_enable = 1'b1;
    tick(2);
    clr_overrun = 1'b1;
    tick(1);
    check_eq("setclr_pulse", pulse2, 1);
    check_eq("setclr_bus", bus2, 8'h33);
    check_eq("setclr_ovr", ovr2, 1);
    clr_overrun = 1'b0;
    tick(2);
    bus_enable = 1'b0;
    tick(5);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    check_eq("setclr_cleared", ovr2, 0);

    // Capture coinciding with a consume: valid stays, no overrun.
    unsync_bus = 8'h44;
    bus_enable = 1'b1;
    tick(2);
    sync_ready = 1'b1;
    tick(1);
    sync_ready = 1'b0;
    check_eq("coin_pulse", pulse2, 1);
    check_eq("coin_bus", bus2, 8'h44);
    check_eq("coin_valid", valid2, 1);
    check_eq("coin_ovr", ovr2, 0);
    tick(1);
    check_eq("coin_ovr_after", ovr2, 0);
    check_eq("coin_valid_after", valid2, 1);
    bus_enable = 1'b0;
    tick(6);

    // N=3: reset two cycles into a transfer, enable still high at release.
    unsync_bus = 8'h55;
    bus_enable = 1'b1;
    tick(2);
    reset_n = 1'b0;
    tick(1);
    check_eq("midrst_pulse3_a", pulse3, 0);
    tick(1);
    check_eq("midrst_pulse3_b", pulse3, 0);
    check_eq("midrst_valid3", valid3, 0);
    check_eq("midrst_bus3", bus3, 8'h00);
    reset_n = 1'b1;
    tick(1);
    check_eq("rel_e1", pulse3, 0);
    tick(1);
    check_eq("rel_e2", pulse3, 0);
    tick(1);
    check_eq("rel_e3", pulse3, 0);
    tick(1);
    check_eq("rel_e4_pulse", pulse3, 1);
    check_eq("rel_e4_bus", bus3, 8'h55);
    check_eq("rel_e4_valid", valid3, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_eq("rel_single", pulse3, 0);
    end
    bus_enable = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
